// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among NUM_CH requesters with a single transaction in flight.
// Round-robin selection by default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module mem_port_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned BE_W  = DATA_W / 8,
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    input  logic [NUM_CH*BE_W-1:0]   ch_byte_enable,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [BE_W-1:0]          mem_byte_enable,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_idx
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BE_W-1:0]     r_mem_be;
    logic [IDX_W-1:0]    r_grant_idx;

    logic [NUM_CH-1:0]   w_req;
    logic                w_found;
    logic [IDX_W-1:0]    w_sel;
    logic [IDX_W-1:0]    w_cand;
    logic                w_load;
    logic                w_done;

    assign w_req = ch_read | ch_write;

    // Requester selection; descending scan so the closest candidate is assigned last and wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int unsigned i = NUM_CH; i >= 1; i--) begin
            w_cand = IDX_W'(i - 1);
            if (w_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
`else
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            w_cand = IDX_W'((32'(r_grant_idx) + k) % NUM_CH);
            if (w_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_load      = 1'b1;
                end
            end
            S_BUSY: begin
                if (mem_resp) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shared port registers: captured at grant, untouched until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_grant_idx   <= IDX_W'(NUM_CH - 1);
        end else if (w_load) begin
            r_mem_write   <= ch_write[w_sel];
            r_mem_read    <= ch_read[w_sel] & ~ch_write[w_sel];
            r_mem_address <= ch_address[32'(w_sel) * ADDR_W +: ADDR_W];
            r_mem_wdata   <= ch_wdata[32'(w_sel) * DATA_W +: DATA_W];
            r_mem_be      <= ch_byte_enable[32'(w_sel) * BE_W +: BE_W];
            r_grant_idx   <= w_sel;
        end else if (w_done) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end
    end

    // Completion is steered to the granted channel in the same cycle as mem_resp.
    always_comb begin
        ch_resp = '0;
        if ((r_state == S_BUSY) && mem_resp) begin
            ch_resp[r_grant_idx] = 1'b1;
        end
    end

    assign ch_rdata        = mem_rdata;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_mem_address;
    assign mem_wdata       = r_mem_wdata;
    assign mem_byte_enable = r_mem_be;
    assign busy            = (r_state == S_BUSY);
    assign grant_idx       = r_grant_idx;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that shares one memory port among several requesters.
- Requesters are, for example, the instruction fetch and data access sides of the pipelined core.
- Every channel and the shared port use the core's existing handshake: read/write is held until a one-cycle resp.
- At most one transaction is outstanding; grants are round-robin.
- Address, data and byte enables are latched at grant, so requester-side changes cannot corrupt an in-flight access.

Parameters:
- NUM_CH, 2, number of requester channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8. BE_W = DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ch_read  in  NUM_CH  per-channel read request
- ch_write  in  NUM_CH  per-channel write request
- ch_address  in  NUM_CH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NUM_CH*DATA_W  packed per channel, same layout
- ch_byte_enable  in  NUM_CH*BE_W  packed per channel, same layout
- ch_resp  out  NUM_CH  one-hot completion pulse to the granted channel
- ch_rdata  out  DATA_W  read data, broadcast to all channels; valid only with ch_resp
- mem_read  out  1  shared port read
- mem_write  out  1  shared port write
- mem_address  out  ADDR_W  shared port address
- mem_wdata  out  DATA_W  shared port write data
- mem_byte_enable  out  BE_W  shared port byte enables
- mem_rdata  in  DATA_W  memory read data
- mem_resp  in  1  memory completion
- busy  out  1  a transaction is outstanding
- grant_idx  out  $clog2(NUM_CH) (min 1)  index of the current or last granted channel

Behaviour:
- Reset values:
  - mem_read, mem_write, busy = 0.
  - mem_address, mem_wdata, mem_byte_enable = 0.
  - ch_resp = 0.
  - grant_idx = NUM_CH-1, so channel 0 wins first.
  - FSM = IDLE.
- A channel requests when ch_read[i] | ch_write[i].
- FSM IDLE:
  - If any channel requests, choose the first requester scanning from grant_idx+1 upward, modulo NUM_CH.
  - On that same edge: latch the chosen channel's address, wdata and byte_enable into the mem_* registers; set grant_idx; go to BUSY.
  - mem_write <= ch_write[g]. mem_read <= ch_read[g] & ~ch_write[g]; write wins if both are asserted (illegal, but defined).
  - Latency: a request sampled at edge N drives mem_read/mem_write from N+1.
- FSM BUSY:
  - mem_* outputs are held stable regardless of channel inputs.
  - busy = 1.
  - When mem_resp = 1: ch_resp[grant_idx] = 1 combinationally in the same cycle, and ch_rdata = mem_rdata (always passed through).
  - On that edge: clear mem_read and mem_write, go to IDLE.
  - An address is never re-presented after resp.
- Back-to-back: after a resp cycle, at least one IDLE cycle occurs before the next mem_read/mem_write assertion. Peak throughput is one transaction per (memory latency + 2) cycles.
- Requester contract: deassert the request in the cycle after its ch_resp. A request dropped mid-transaction is ignored; the transaction completes and ch_resp still pulses.
- mem_resp while IDLE: ignored, no ch_resp.
- Fairness: with all NUM_CH channels requesting continuously, each is served once per NUM_CH grants.
- Reset asserted mid-transaction: all state returns to reset values immediately (asynchronously). The pending resp is dropped and no ch_resp is issued.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. grant_idx is still updated and reported but does not affect selection. Starvation of high-index channels is permitted.
- Undefined (default): round-robin as above.

Test Plan:
1. Reset, then ch_read[0]=1, ch_address[0]=0x0000_0060; memory responds 3 cycles after mem_read. Required: mem_read rises 1 cycle after the request with mem_address=0x60; ch_resp[0] pulses together with mem_resp; ch_rdata=0xDEAD_BEEF; busy falls the next cycle.
2. NUM_CH=2, both channels requesting from reset. Required: grant order 0,1,0,1 over 4 transactions; grant_idx follows; at least one idle cycle between transactions.
3. Channel 1 write: address 0x100, wdata 0x1234_5678, be 4'b0011. Change ch_address[1] to 0x200 while BUSY. Required: mem_address stays 0x100; mem_write=1, mem_read=0; be=0011.
4. ch_read[0] and ch_write[0] asserted together. Required: mem_write=1, mem_read=0. Separately, a mem_resp pulse while IDLE produces no ch_resp.
5. Assert rst 2 cycles into a BUSY read. Required: all outputs go to reset values without waiting for a clk edge; the later mem_resp is ignored; the next grant goes to channel 0.
6. With MEM_ARB_FIXED_PRIO_EN defined and NUM_CH=3, all three channels requesting. Required: channel 0 is granted every transaction; after channel 0 drops its request, channel 1 is granted ahead of channel 2.
